// File: rtl/u_scan_pkg.sv
// Shared types for the u_scan bit enumerator.
package u_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/u_scan_ffs.sv
// Combinational find-first over a residual vector: index of the first bit equal
// to MATCH_BIT (LSB- or MSB-first), plus any-match and exactly-one-match flags.
module u_scan_ffs #(
    parameter int W         = 32,
    parameter int MATCH_BIT = 1,
    parameter int LSB       = 1,
    localparam int IW       = $clog2(W)
) (
    input  logic [W-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o,
    output logic          one_o
);

    logic [W-1:0] m;

    assign m = (MATCH_BIT != 0) ? vec_i : ~vec_i;

    // Later loop iterations win, so walk from the far end toward the preferred end.
    always_comb begin
        idx_o = '0;
        if (LSB != 0) begin
            for (int i = W - 1; i >= 0; i--)
                if (m[i]) idx_o = IW'(i);
        end else begin
            for (int i = 0; i < W; i++)
                if (m[i]) idx_o = IW'(i);
        end
    end

    assign any_o = |m;
    assign one_o = any_o && ((m & (m - W'(1))) == '0);

endmodule

// File: rtl/u_scan.sv
// Enumerates the positions of matching bits in an accepted vector, one beat per
// handshake. Optional U_SCAN_COUNT_EN adds o_cnt (match count of the vector).
module u_scan
    import u_scan_pkg::*;
#(
    parameter int W         = 32,
    parameter int MATCH_BIT = 1,
    parameter int LSB       = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_x_vld,
    input  logic [W-1:0]         i_x,
    output logic                 o_x_rdy,
    output logic                 o_idx_vld,
    output logic [$clog2(W)-1:0] o_idx,
    output logic                 o_idx_last,
    output logic                 o_none,
`ifdef U_SCAN_COUNT_EN
    output logic [$clog2(W+1)-1:0] o_cnt,
`endif
    input  logic                 i_idx_rdy
);

    localparam int IW = $clog2(W);

    state_e         state_q, state_d;
    logic [W-1:0]   r_q, r_d;
    logic [IW-1:0]  f_idx;
    logic           f_any, f_one;
    logic           hs;

    u_scan_ffs #(.W(W), .MATCH_BIT(MATCH_BIT), .LSB(LSB)) u_ffs (
        .vec_i (r_q),
        .idx_o (f_idx),
        .any_o (f_any),
        .one_o (f_one)
    );

    // Outputs depend only on registered state, so they stay stable under stall.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        o_x_rdy    = (state_q == IDLE);
        o_idx_vld  = (state_q == SCAN);
        o_none     = o_idx_vld & ~f_any;
        o_idx      = (o_idx_vld && f_any) ? f_idx : '0;
        o_idx_last = o_idx_vld & (f_one | ~f_any);
        hs         = o_idx_vld & i_idx_rdy;
        case (state_q)
            IDLE: begin
                if (i_x_vld) begin
                    r_d     = i_x;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hs) begin
                    if (f_any) r_d = r_q ^ (W'(1) << f_idx);
                    if (o_idx_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

`ifdef U_SCAN_COUNT_EN
    logic [$clog2(W+1)-1:0] cnt_q, cnt_d;
    logic [W-1:0]           xm;

    assign xm = (MATCH_BIT != 0) ? i_x : ~i_x;

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < W; i++)
            cnt_d = cnt_d + ($clog2(W+1))'(xm[i]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            cnt_q <= '0;
        else if (o_x_rdy && i_x_vld)
            cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;
`endif

endmodule
